// File: rtl/comparator_pkg.sv
// Shared types and constants for the MSB-first serial magnitude comparator.
// State encoding, result bundle and default word width.
package comparator_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_res_t;

endpackage

// File: rtl/bit_cmp.sv
// Single-bit magnitude compare of one serial pair.
// Purely combinational.
module bit_cmp (
  input  logic a,
  input  logic b,
  output logic eq,
  output logic gt,
  output logic lt
);

  assign eq = ~(a ^ b);
  assign gt = a & ~b;
  assign lt = ~a & b;

endmodule

// File: rtl/serial_comparator.sv
// Compares two WIDTH-bit words streamed MSB first, one pair per valid cycle.
// The first differing pair decides; the result is held until the next start.
module serial_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic equals,
  output logic a_greater,
  output logic b_greater
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  cmp_res_t flg, flg_n;
  cmp_res_t res, res_n;

  logic pair_eq;
  logic pair_gt;
  logic pair_lt;

  bit_cmp u_bit_cmp (
    .a  (a_bit),
    .b  (b_bit),
    .eq (pair_eq),
    .gt (pair_gt),
    .lt (pair_lt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      flg   <= '0;
      res   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      flg   <= flg_n;
      res   <= res_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    flg_n   = flg;
    res_n   = res;
    unique case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (start) begin
          state_n = SHIFT;
          cnt_n   = '0;
          flg_n   = '{eq: 1'b1, gt: 1'b0, lt: 1'b0};
          res_n   = '0;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          cnt_n = cnt + CW'(1);
          // Only the first differing pair may decide.
          if (flg.eq && !pair_eq) begin
            flg_n = '{eq: 1'b0, gt: pair_gt, lt: pair_lt};
          end
          if (cnt == LAST) begin
            state_n = DONE;
            res_n   = flg_n;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state == SHIFT);
  assign done      = (state == DONE);
  assign equals    = res.eq;
  assign a_greater = res.gt;
  assign b_greater = res.lt;

endmodule

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 Parameter WIDTH, default 8, the number of bits per compared word; legal range is 2..32.
REQ-002 Ports, listed as name, direction, width, meaning:
- clk, in, 1, the single clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, begin a new comparison.
- bit_valid, in, 1, a_bit/b_bit carry a valid pair this cycle.
- a_bit, in, 1, serial bit of word A, MSB first.
- b_bit, in, 1, serial bit of word B, MSB first.
- busy, out, 1, a comparison is in progress.
- done, out, 1, one-cycle pulse when a result is complete.
- equals, out, 1, A == B.
- a_greater, out, 1, A > B (unsigned).
- b_greater, out, 1, A < B (unsigned).
REQ-003 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high, and no other clock or asynchronous path SHALL exist.

Function
REQ-004 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-005 IDLE: start=1 moves to SHIFT next cycle, clears the bit counter, sets the internal equal flag to 1 and clears the decided flags; bit_valid is ignored.
REQ-006 SHIFT: each cycle with bit_valid=1 consumes one bit pair; cycles with bit_valid=0 stall with no state change.
REQ-007 Magnitude rule: the first pair (MSB first) with a_bit != b_bit latches a_greater=a_bit and b_greater=b_bit, clears the equal flag, and later pairs SHALL NOT change the decision.
REQ-008 The counter SHALL be $clog2(WIDTH+1) bits and SHALL increment per consumed pair; on the WIDTH-th pair the FSM moves to DONE.
REQ-009 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-010 In the DONE cycle, equals/a_greater/b_greater SHALL present the final result, and exactly one of the three SHALL be 1.
REQ-011 Result outputs SHALL hold their value from DONE until the next accepted start, and SHALL read 0 while busy.
REQ-012 busy SHALL be 1 in SHIFT and 0 in IDLE and DONE.
REQ-013 Latency: the last valid pair in cycle N gives done=1 in cycle N+1; with continuous bit_valid, start in cycle 0 gives done in cycle WIDTH+1.
REQ-014 start while in SHIFT SHALL be ignored and SHALL NOT restart the comparison.
REQ-015 start in the DONE cycle SHALL be honoured: the next cycle is SHIFT with the counter cleared, and results clear to 0.
REQ-016 bit_valid in the same cycle as an accepted start SHALL NOT be consumed; the first pair is taken in SHIFT only.

Reset
REQ-017 When reset=1 at a clk edge, the block SHALL go to IDLE and clear the counter, busy, done, equals, a_greater and b_greater to 0.
REQ-018 Reset SHALL take priority over start and bit_valid in the same cycle.
REQ-019 Reset mid-SHIFT SHALL discard the partial comparison and SHALL NOT produce done.

Structure
REQ-020 Package comparator_pkg SHALL hold the state_t enum (IDLE, SHIFT, DONE) and the constant DEFAULT_WIDTH = 8.
REQ-021 Sub-module bit_cmp SHALL be purely combinational with inputs a, b and outputs eq (XNOR), gt (a & ~b) and lt (~a & b), and SHALL be instantiated once.
REQ-022 All state SHALL sit in always_ff blocks on clk, with next-state logic in always_comb.

Verification
REQ-023 A bench SHALL cover these directed scenarios (WIDTH=8, continuous bit_valid unless stated):
- A=0xA5, B=0xA5 -> done in cycle 9 after start, equals=1, a_greater=0, b_greater=0.
- A=0x80, B=0x7F -> MSB differs, a_greater=1; the remaining bits SHALL NOT flip the result.
- A=0x3C, B=0x3D -> b_greater=1 decided on the last bit, done one cycle later.
- A=0x00, B=0xFF with bit_valid low on alternate cycles -> done after 16 SHIFT cycles, b_greater=1, busy=1 throughout SHIFT.
- Start again in SHIFT after 3 bits -> ignored and result unchanged; then reset after 5 bits -> IDLE, no done pulse, all outputs 0.
- start in the DONE cycle with A=0xFF, B=0xFF -> back-to-back comparison, results cleared while busy, second done gives equals=1.
